contador_mod: RTL and testbench

Parametrised successor to the free-running binary counter. Adds a selectable width, a programmable modulo, up/down direction, a clock-enable prescaler, parallel load, a terminal-count pulse and a sticky overflow flag. Used as the general counting/timebase primitive: LED dividers, timeouts and event counters. Single clock domain.

---
 rtl/contador_mod.sv | 81 ++++++++
 tb/tb_contador_mod.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/contador_mod.sv
// Parametrised up/down counter with modulo, prescaler, parallel load,
// terminal-count pulse and sticky overflow. Define CONTADOR_SAT_EN for saturating mode.
module contador_mod #(
   parameter int unsigned     WIDTH   = 26,
   parameter longint unsigned MODULO  = 0,
   parameter int unsigned     PRESC   = 1,
   parameter longint unsigned RST_VAL = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] data,
   output logic             tc,
   output logic             ovf
);

   localparam longint unsigned SPAN  = 64'd1 << WIDTH;
   localparam longint unsigned MAX_L = (MODULO == 0 || MODULO == SPAN) ? SPAN - 1 : MODULO - 1;
   localparam logic [WIDTH-1:0] MAX  = WIDTH'(MAX_L);
   localparam int unsigned     PW    = (PRESC > 1) ? $clog2(PRESC) : 1;
   localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESC - 1);

   logic [PW-1:0]    presc_q, presc_d;
   logic [WIDTH-1:0] data_d;
   logic             tc_d, ovf_d;
   logic             step, at_bound;

   always_comb begin
      presc_d  = presc_q;
      data_d   = data;
      tc_d     = 1'b0;
      ovf_d    = ovf;
      step     = 1'b0;
      at_bound = 1'b0;
      if (load) begin
         // extra zero bit keeps the clamp compare meaningful when MAX is all ones
         data_d  = ({1'b0, load_val} > {1'b0, MAX}) ? MAX : load_val;
         presc_d = '0;
         ovf_d   = 1'b0;
      end else if (ena) begin
         if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            step    = 1'b1;
         end else begin
            presc_d = presc_q + PW'(1);
         end
         if (step) begin
            at_bound = up ? (data == MAX) : (data == '0);
            if (at_bound) begin
               tc_d  = 1'b1;
               ovf_d = 1'b1;
`ifdef CONTADOR_SAT_EN
               data_d = data;
`else
               data_d = up ? '0 : MAX;
`endif
            end else begin
               data_d = up ? data + WIDTH'(1) : data - WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data    <= WIDTH'(RST_VAL);
         presc_q <= '0;
         tc      <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         data    <= data_d;
         presc_q <= presc_d;
         tc      <= tc_d;
         ovf     <= ovf_d;
      end
   end

endmodule

// File: tb/tb_contador_mod.sv
// Bench for contador_mod: five parameter sets share one stimulus stream, an
// arithmetic model is compared every cycle, plus hand-computed checkpoints.
module tb_contador_mod;

`ifdef CONTADOR_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   localparam longint unsigned MXV [5] = '{(64'd1 << 26) - 1, 9, 9, 15, 0};
   localparam int unsigned     WV  [5] = '{26, 4, 8, 4, 2};
   localparam int unsigned     PV  [5] = '{1, 1, 4, 1, 1};
   localparam longint unsigned RV  [5] = '{0, 0, 3, 0, 0};

   logic        clk = 1'b0;
   logic        rst, ena, up, load;
   logic [25:0] lv;

   logic [25:0] d0;
   logic [3:0]  d1;
   logic [7:0]  d2;
   logic [3:0]  d3;
   logic [1:0]  d4;
   logic        tc0, tc1, tc2, tc3, tc4;
   logic        ovf0, ovf1, ovf2, ovf3, ovf4;

   int unsigned total = 0;
   int unsigned bad   = 0;
   bit          seen  = 1'b0;

   longint unsigned m_data [5];
   longint unsigned m_pc   [5];
   bit              m_tc   [5];
   bit              m_ovf  [5];

   longint unsigned act_d [5];
   bit              act_tc [5];
   bit              act_ovf [5];

   always #5 clk = ~clk;

   contador_mod u0 (.clk(clk), .rst(rst), .ena(ena), .up(up), .load(load),
                    .load_val(lv), .data(d0), .tc(tc0), .ovf(ovf0));
   contador_mod #(.WIDTH(4), .MODULO(10)) u1 (.clk(clk), .rst(rst), .ena(ena), .up(up),
                    .load(load), .load_val(lv[3:0]), .data(d1), .tc(tc1), .ovf(ovf1));
   contador_mod #(.WIDTH(8), .MODULO(10), .PRESC(4), .RST_VAL(3)) u2 (.clk(clk), .rst(rst),
                    .ena(ena), .up(up), .load(load), .load_val(lv[7:0]), .data(d2), .tc(tc2), .ovf(ovf2));
   contador_mod #(.WIDTH(4), .MODULO(16)) u3 (.clk(clk), .rst(rst), .ena(ena), .up(up),
                    .load(load), .load_val(lv[3:0]), .data(d3), .tc(tc3), .ovf(ovf3));
   contador_mod #(.WIDTH(2), .MODULO(1)) u4 (.clk(clk), .rst(rst), .ena(ena), .up(up),
                    .load(load), .load_val(lv[1:0]), .data(d4), .tc(tc4), .ovf(ovf4));

   always_comb begin
      act_d[0] = 64'(d0); act_d[1] = 64'(d1); act_d[2] = 64'(d2);
      act_d[3] = 64'(d3); act_d[4] = 64'(d4);
      act_tc[0] = tc0; act_tc[1] = tc1; act_tc[2] = tc2; act_tc[3] = tc3; act_tc[4] = tc4;
      act_ovf[0] = ovf0; act_ovf[1] = ovf1; act_ovf[2] = ovf2; act_ovf[3] = ovf3; act_ovf[4] = ovf4;
   end

   task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: count modulo (MAX+1), step on every PRESC-th enabled cycle
   always @(posedge clk) begin
      if (rst) seen <= 1'b1;
      for (int i = 0; i < 5; i++) begin
         longint unsigned nd, np, lm;
         bit w;
         nd = m_data[i];
         np = m_pc[i];
         w  = 1'b0;
         if (rst) begin
            nd = RV[i];
            np = 0;
         end else if (load) begin
            lm = 64'(lv) % (64'd1 << WV[i]);
            nd = (lm > MXV[i]) ? MXV[i] : lm;
            np = 0;
         end else if (ena) begin
            np = (np + 1) % PV[i];
            if (np == 0) begin
               if (up) begin
                  if (nd == MXV[i]) begin w = 1'b1; nd = SAT ? nd : 0; end
                  else nd = nd + 1;
               end else begin
                  if (nd == 0) begin w = 1'b1; nd = SAT ? nd : MXV[i]; end
                  else nd = nd - 1;
               end
            end
         end
         m_data[i] <= nd;
         m_pc[i]   <= np;
         m_tc[i]   <= w;
         m_ovf[i]  <= (rst || load) ? 1'b0 : (m_ovf[i] | w);
      end
   end

   always @(negedge clk) begin
      if (seen) begin
         for (int i = 0; i < 5; i++) begin
            chk($sformatf("u%0d_data", i), act_d[i], m_data[i]);
            chk($sformatf("u%0d_tc", i), 64'(act_tc[i]), 64'(m_tc[i]));
            chk($sformatf("u%0d_ovf", i), 64'(act_ovf[i]), 64'(m_ovf[i]));
         end
      end
   end

   initial begin
      rst = 1'b1; ena = 1'b1; up = 1'b1; load = 1'b0; lv = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_d0", 64'(d0), 0);
      chk("rst_d2", 64'(d2), 3);
      chk("rst_ovf1", 64'(ovf1), 0);
      rst = 1'b0;

      // free-running count for 100 cycles
      repeat (100) @(posedge clk);
      @(negedge clk);
      chk("t1_d0", 64'(d0), 100);
      chk("t1_tc0", 64'(tc0), 0);
      chk("t1_ovf0", 64'(ovf0), 0);
      chk("t1_d1", 64'(d1), SAT ? 9 : 0);
      chk("t1_tc1", 64'(tc1), 1);
      chk("t1_ovf1", 64'(ovf1), 1);
      chk("t1_d2", 64'(d2), SAT ? 9 : 8);
      chk("t1_tc2", 64'(tc2), SAT ? 1 : 0);
      chk("t1_d3", 64'(d3), SAT ? 15 : 4);
      chk("t1_tc4", 64'(tc4), 1);
      @(negedge clk);
      chk("t1_tc4_again", 64'(tc4), 1);
      chk("t1_d0_101", 64'(d0), 101);

      // count down after reset
      rst = 1'b1; up = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("t3_d1_first", 64'(d1), SAT ? 0 : 9);
      chk("t3_tc1_first", 64'(tc1), 1);
      repeat (4) @(negedge clk);
      chk("t3_d1_mid", 64'(d1), SAT ? 0 : 5);
      chk("t3_tc1_mid", 64'(tc1), SAT ? 1 : 0);
      repeat (6) @(negedge clk);
      chk("t3_d1_wrap2", 64'(d1), SAT ? 0 : 9);
      chk("t3_tc1_wrap2", 64'(tc1), 1);

      // prescaler and enable gap
      rst = 1'b1; up = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("t4_d2_pre", 64'(d2), 3);
      @(negedge clk);
      chk("t4_d2_step", 64'(d2), 4);
      repeat (2) @(negedge clk);
      ena = 1'b0;
      repeat (3) @(negedge clk);
      chk("t4_d2_hold", 64'(d2), 4);
      ena = 1'b1;
      @(negedge clk);
      chk("t4_d2_late", 64'(d2), 4);
      @(negedge clk);
      chk("t4_d2_step2", 64'(d2), 5);

      // loads
      load = 1'b1; lv = 26'd7;
      @(negedge clk);
      load = 1'b0;
      chk("t5_d1_load", 64'(d1), 7);
      chk("t5_d2_load", 64'(d2), 7);
      chk("t5_ovf1_clr", 64'(ovf1), 0);
      chk("t5_ovf2_clr", 64'(ovf2), 0);
      chk("t5_d4_clamp", 64'(d4), 0);
      repeat (3) @(negedge clk);
      chk("t5_d2_wait", 64'(d2), 7);
      @(negedge clk);
      chk("t5_d2_step", 64'(d2), 8);
      chk("t5_d1_run", 64'(d1), SAT ? 9 : 1);
      load = 1'b1; lv = 26'd15;
      @(negedge clk);
      load = 1'b0;
      chk("t5_d1_clamp", 64'(d1), 9);
      chk("t5_d2_clamp", 64'(d2), 9);
      chk("t5_d3_noclamp", 64'(d3), 15);
      chk("t5_d0_load", 64'(d0), 15);
      rst = 1'b1; load = 1'b1; lv = 26'd5;
      @(negedge clk);
      rst = 1'b0; load = 1'b0;
      chk("t5_rst_over_load_d2", 64'(d2), 3);
      chk("t5_rst_over_load_d1", 64'(d1), 0);

      // boundary behaviour on the 4-bit natural-range counter
      load = 1'b1; lv = 26'd14;
      @(negedge clk);
      load = 1'b0; up = 1'b1;
      chk("t6_d3_load", 64'(d3), 14);
      @(negedge clk);
      chk("t6_d3_max", 64'(d3), 15);
      chk("t6_tc3_max", 64'(tc3), 0);
      @(negedge clk);
      chk("t6_d3_edge", 64'(d3), SAT ? 15 : 0);
      chk("t6_tc3_edge", 64'(tc3), 1);
      chk("t6_ovf3_edge", 64'(ovf3), 1);
      @(negedge clk);
      chk("t6_d3_after", 64'(d3), SAT ? 15 : 1);
      chk("t6_tc3_after", 64'(tc3), SAT ? 1 : 0);
      up = 1'b0;
      @(negedge clk);
      chk("t6_d3_down1", 64'(d3), SAT ? 14 : 0);
      chk("t6_tc3_down1", 64'(tc3), 0);
      @(negedge clk);
      chk("t6_d3_down2", 64'(d3), SAT ? 13 : 15);
      chk("t6_tc3_down2", 64'(tc3), SAT ? 0 : 1);

      @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
